// File: rtl/pw_sequence_ctrl.sv
// pw_sequence_ctrl
// Password-entry sequencer. Rising edges on the four elongated key pulses
// become key symbols. A CODE_LEN-symbol entry is compared on the fly against
// PASSWORD without ever being stored. The controller drives unlock, fail and
// lockout status and exposes its FSM state on state_dbg.
//
// Press event: press_q is a one-cycle strobe registered from the key edges.
// It is valid for exactly one cycle and there is no back-pressure. The FSM
// consumes it only in IDLE and ENTRY. In every other state the strobe is
// dropped, not queued.
module pw_sequence_ctrl #(
    parameter int unsigned CODE_LEN    = 4,
    parameter logic [15:0] PASSWORD    = 16'h00E4,
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned TIMEOUT_CYC = 500_000_000,
    parameter int unsigned UNLOCK_CYC  = 300_000_000,
    parameter int unsigned LOCK_CYC    = 1_000_000_000,
    localparam int unsigned FCW = ($clog2(MAX_FAILS + 1) < 2) ? 2 : $clog2(MAX_FAILS + 1)
) (
    input  logic           clkin,
    input  logic           reset,
    input  logic           key_a,
    input  logic           key_b,
    input  logic           key_c,
    input  logic           key_d,
    output logic           unlock,
    output logic           fail,
    output logic           locked,
    output logic [3:0]     digit_cnt,
    output logic [FCW-1:0] fail_cnt,
    output logic [2:0]     state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_CHECK    = 3'd2,
        S_FAIL     = 3'd3,
        S_UNLOCKED = 3'd4,
        S_LOCKOUT  = 3'd5
    } state_t;

    // Terminal timer values: a phase lasting N cycles ends when the timer
    // has counted N-1 cycles past entry.
    localparam logic [31:0]    TO_LAST  = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;
    localparam logic [31:0]    UN_LAST  = (UNLOCK_CYC  > 0) ? 32'(UNLOCK_CYC  - 1) : 32'd0;
    localparam logic [31:0]    LK_LAST  = (LOCK_CYC    > 0) ? 32'(LOCK_CYC    - 1) : 32'd0;
    localparam logic [3:0]     CODE_LEN_C = 4'(CODE_LEN);
    localparam logic [FCW-1:0] MAX_F    = FCW'(MAX_FAILS);

    // ------------------------------------------------------------------
    // Key edge detection
    // ------------------------------------------------------------------
    logic [3:0] keys;
    logic [3:0] key_prev_q;
    logic [3:0] rise;
    logic       press_d, press_q;
    logic       multi_d, multi_q;
    logic [1:0] sym_d, sym_q;

    assign keys = {key_d, key_c, key_b, key_a};
    assign rise = keys & ~key_prev_q;

    // Decode this cycle's rising edges into one press, its symbol and
    // whether more than one key rose together.
    always_comb begin
        press_d = |rise;
        multi_d = (rise & (rise - 4'd1)) != 4'd0;
        sym_d   = 2'd0;
        if (rise[3]) begin
            sym_d = 2'd3;
        end else if (rise[2]) begin
            sym_d = 2'd2;
        end else if (rise[1]) begin
            sym_d = 2'd1;
        end
    end

    // Register the press strobe. The edge history follows live key levels
    // even in reset, so a key held across reset never looks like a press.
    always_ff @(posedge clkin) begin
        key_prev_q <= keys;
        if (reset) begin
            press_q <= 1'b0;
            multi_q <= 1'b0;
            sym_q   <= 2'd0;
        end else begin
            press_q <= press_d;
            multi_q <= multi_d;
            sym_q   <= sym_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [3:0]     digit_cnt_q, digit_cnt_d;
    logic           mismatch_q, mismatch_d;
    logic [FCW-1:0] fail_cnt_q, fail_cnt_d;
    logic [31:0]    timer_q, timer_d;
    logic [1:0]     exp_sym;
    logic           sym_bad;
    logic [FCW-1:0] fail_inc;

    // Symbol expected at the current position. An invalid multi-key press
    // is always treated as wrong.
    assign exp_sym  = PASSWORD[{digit_cnt_q[2:0], 1'b0} +: 2];
    assign sym_bad  = multi_q | (sym_q != exp_sym);
    assign fail_inc = (fail_cnt_q == MAX_F) ? fail_cnt_q : fail_cnt_q + FCW'(1);

    // Next-state, counter and timer logic.
    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        mismatch_d  = mismatch_q;
        fail_cnt_d  = fail_cnt_q;
        timer_d     = timer_q;
        unique case (state_q)
            S_IDLE: begin
                timer_d = 32'd0;
                if (press_q) begin
                    state_d     = S_ENTRY;
                    digit_cnt_d = 4'd1;
                    mismatch_d  = sym_bad;
                end
            end
            S_ENTRY: begin
                if (digit_cnt_q >= CODE_LEN_C) begin
                    // Entry complete; any press arriving now is dropped.
                    state_d = S_CHECK;
                    timer_d = 32'd0;
                end else if (press_q) begin
                    digit_cnt_d = digit_cnt_q + 4'd1;
                    mismatch_d  = mismatch_q | sym_bad;
                    timer_d     = 32'd0;
                end else if (timer_q >= TO_LAST) begin
                    // Abandoned entry: no failure is recorded.
                    state_d     = S_IDLE;
                    digit_cnt_d = 4'd0;
                    mismatch_d  = 1'b0;
                    timer_d     = 32'd0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_CHECK: begin
                timer_d    = 32'd0;
                mismatch_d = 1'b0;
                if (!mismatch_q) begin
                    state_d     = S_UNLOCKED;
                    fail_cnt_d  = '0;
                    digit_cnt_d = 4'd0;
                end else begin
                    state_d = S_FAIL;
                end
            end
            S_FAIL: begin
                timer_d     = 32'd0;
                digit_cnt_d = 4'd0;
                fail_cnt_d  = fail_inc;
                if (fail_inc == MAX_F) begin
                    state_d = S_LOCKOUT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_UNLOCKED: begin
                if (timer_q >= UN_LAST) begin
                    state_d = S_IDLE;
                    timer_d = 32'd0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_LOCKOUT: begin
                if (timer_q >= LK_LAST) begin
                    state_d    = S_IDLE;
                    fail_cnt_d = '0;
                    timer_d    = 32'd0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                digit_cnt_d = 4'd0;
                mismatch_d  = 1'b0;
                fail_cnt_d  = '0;
                timer_d     = 32'd0;
            end
        endcase
    end

    // State, counters and timer registers with synchronous reset.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= S_IDLE;
            digit_cnt_q <= 4'd0;
            mismatch_q  <= 1'b0;
            fail_cnt_q  <= '0;
            timer_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            mismatch_q  <= mismatch_d;
            fail_cnt_q  <= fail_cnt_d;
            timer_q     <= timer_d;
        end
    end

    assign unlock    = (state_q == S_UNLOCKED);
    assign fail      = (state_q == S_FAIL);
    assign locked    = (state_q == S_LOCKOUT);
    assign digit_cnt = digit_cnt_q;
    assign fail_cnt  = fail_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pw_sequence_ctrl.sv
// Testbench for pw_sequence_ctrl: randomized key presses, an entry-level
// reference model that predicts observable events, and a monitor that
// compares DUT events against the expected queue.
module tb_pw_sequence_ctrl;

    localparam int          CODE_LEN  = 4;
    localparam logic [15:0] PW        = 16'h00E4;
    localparam int          MAX_FAILS = 3;
    localparam int          TIMEOUT   = 1500;
    localparam int          UNLOCK    = 50;
    localparam int          LOCK      = 100;
    localparam int          W         = 36;

    localparam logic [3:0] EV_DIGIT = 4'd1;
    localparam logic [3:0] EV_FCNT  = 4'd2;
    localparam logic [3:0] EV_FAIL  = 4'd3;
    localparam logic [3:0] EV_URISE = 4'd4;
    localparam logic [3:0] EV_LRISE = 4'd5;
    localparam logic [3:0] EV_UEND  = 4'd6;
    localparam logic [3:0] EV_LEND  = 4'd7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] keys = 4'd0;
    logic       unlock, fail, locked;
    logic [3:0] digit_cnt;
    logic [1:0] fail_cnt;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    logic [W-1:0] exp_q[$];

    // Reference model state (entry level, not cycle level).
    int m_in_entry, m_cnt, m_mism, m_fails, m_last_k, m_ready_at;

    pw_sequence_ctrl #(
        .CODE_LEN(CODE_LEN), .PASSWORD(PW), .MAX_FAILS(MAX_FAILS),
        .TIMEOUT_CYC(TIMEOUT), .UNLOCK_CYC(UNLOCK), .LOCK_CYC(LOCK)
    ) dut (
        .clkin(clk), .reset(reset),
        .key_a(keys[0]), .key_b(keys[1]), .key_c(keys[2]), .key_d(keys[3]),
        .unlock(unlock), .fail(fail), .locked(locked),
        .digit_cnt(digit_cnt), .fail_cnt(fail_cnt), .state_dbg(state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk(input logic [3:0] t, input int p);
        return {t, 32'(p)};
    endfunction

    function automatic int pw_sym(input int i);
        logic [15:0] v;
        v = PW >> (2 * i);
        return int'(v[1:0]);
    endfunction

    function automatic int sym_of(input logic [3:0] m);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) if (m[i]) s = i;
        return s;
    endfunction

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_ev(input logic [W-1:0] act);
        logic [W-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL event_unexpected: got type %0d val %0d expected none (cycle %0d)",
                     act[35:32], act[31:0], cyc);
        end else begin
            e = exp_q.pop_front();
            if (e == act) n_pass++;
            else $display("FAIL event: got type %0d val %0d expected type %0d val %0d (cycle %0d)",
                          act[35:32], act[31:0], e[35:32], e[31:0], cyc);
        end
    endtask

    // Monitor: turns output changes into events and scores them.
    logic [3:0] p_digit = 4'd0;
    logic [1:0] p_fcnt = 2'd0;
    logic       p_unlock = 1'b0, p_locked = 1'b0;
    int         un_len = 0, lk_len = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (digit_cnt != p_digit) check_ev(mk(EV_DIGIT, int'(digit_cnt)));
            if (fail_cnt != p_fcnt) check_ev(mk(EV_FCNT, int'(fail_cnt)));
            if (fail) check_ev(mk(EV_FAIL, cyc));
            if (unlock && !p_unlock) check_ev(mk(EV_URISE, cyc));
            if (locked && !p_locked) check_ev(mk(EV_LRISE, cyc));
            if (!unlock && p_unlock) check_ev(mk(EV_UEND, un_len));
            if (!locked && p_locked) check_ev(mk(EV_LEND, lk_len));
        end
        un_len   = unlock ? un_len + 1 : 0;
        lk_len   = locked ? lk_len + 1 : 0;
        p_digit  = digit_cnt;
        p_fcnt   = fail_cnt;
        p_unlock = unlock;
        p_locked = locked;
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_in_entry = 0; m_cnt = 0; m_mism = 0; m_fails = 0; m_last_k = 0; m_ready_at = 0;
    endtask

    // An entry left idle for more than TIMEOUT cycles is abandoned.
    task automatic model_timeout(input int t);
        if (m_in_entry != 0 && t - m_last_k > TIMEOUT) begin
            exp_q.push_back(mk(EV_DIGIT, 0));
            m_in_entry = 0;
        end
    endtask

    // Key mask first sampled high at edge k.
    task automatic model_press(input logic [3:0] mask, input int k);
        int bad;
        model_timeout(k);
        if (k < m_ready_at) return;
        if (m_in_entry == 0) begin
            m_in_entry = 1; m_cnt = 0; m_mism = 0;
        end
        bad = ($countones(mask) != 1 || sym_of(mask) != pw_sym(m_cnt)) ? 1 : 0;
        m_mism = m_mism | bad;
        m_cnt++;
        m_last_k = k;
        exp_q.push_back(mk(EV_DIGIT, m_cnt));
        if (m_cnt == CODE_LEN) begin
            m_in_entry = 0;
            if (m_mism == 0) begin
                exp_q.push_back(mk(EV_DIGIT, 0));
                if (m_fails != 0) exp_q.push_back(mk(EV_FCNT, 0));
                m_fails = 0;
                exp_q.push_back(mk(EV_URISE, k + 3));
                exp_q.push_back(mk(EV_UEND, UNLOCK));
                m_ready_at = k + 3 + UNLOCK;
            end else begin
                exp_q.push_back(mk(EV_FAIL, k + 3));
                exp_q.push_back(mk(EV_DIGIT, 0));
                m_fails++;
                exp_q.push_back(mk(EV_FCNT, m_fails));
                if (m_fails == MAX_FAILS) begin
                    exp_q.push_back(mk(EV_LRISE, k + 4));
                    exp_q.push_back(mk(EV_FCNT, 0));
                    exp_q.push_back(mk(EV_LEND, LOCK));
                    m_fails = 0;
                    m_ready_at = k + 4 + LOCK;
                end else begin
                    m_ready_at = k + 4;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        model_timeout(cyc + n);
        repeat (n) step();
    endtask

    task automatic press(input logic [3:0] mask, input int gap, input int hold);
        model_press(mask, cyc + gap + 1);
        repeat (gap) step();
        keys = mask;
        repeat (hold) step();
        keys = 4'd0;
    endtask

    task automatic enter_code(input int gap);
        for (int i = 0; i < CODE_LEN; i++) press(4'(1 << pw_sym(i)), gap, 2);
    endtask

    task automatic do_reset(input string tag);
        mon_en = 1'b0;
        exp_q.delete();
        reset = 1'b1;
        step();
        check_eq({tag, "_state"}, int'(state_dbg), 0);
        check_eq({tag, "_unlock"}, int'(unlock), 0);
        check_eq({tag, "_fail"}, int'(fail), 0);
        check_eq({tag, "_locked"}, int'(locked), 0);
        check_eq({tag, "_digit"}, int'(digit_cnt), 0);
        check_eq({tag, "_fcnt"}, int'(fail_cnt), 0);
        step();
        reset = 1'b0;
        step();
        step();
        model_reset();
        mon_en = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] mask;
        int a, b, gap;
        model_reset();
        repeat (3) step();
        do_reset("reset");

        // Correct code, presses about 1000 cycles apart.
        press(4'b0001, 10, 3);
        press(4'b0010, 1000, 3);
        press(4'b0100, 1000, 3);
        press(4'b1000, 1000, 3);
        idle(UNLOCK + 20);
        check_eq("after_unlock_state", int'(state_dbg), 0);

        // Wrong code a,b,d,d.
        press(4'b0001, 5, 2);
        press(4'b0010, 5, 2);
        press(4'b1000, 5, 2);
        press(4'b1000, 5, 2);
        idle(20);
        check_eq("one_fail_cnt", int'(fail_cnt), 1);
        check_eq("one_fail_unlock", int'(unlock), 0);

        // Correct code clears the fail count, then three wrong entries lock.
        enter_code(6);
        idle(UNLOCK + 20);
        for (int e = 0; e < 3; e++)
            for (int i = 0; i < CODE_LEN; i++) press(4'b1000, 4, 2);
        press(4'b0001, 4, 2);
        press(4'b0010, 4, 2);
        check_eq("lock_locked", int'(locked), 1);
        check_eq("lock_digit", int'(digit_cnt), 0);
        idle(LOCK + 20);
        check_eq("after_lock_fcnt", int'(fail_cnt), 0);
        check_eq("after_lock_state", int'(state_dbg), 0);

        // Timeout after one key, then a correct code.
        press(4'b0001, 5, 2);
        idle(TIMEOUT + 100);
        check_eq("timeout_state", int'(state_dbg), 0);
        check_eq("timeout_digit", int'(digit_cnt), 0);
        enter_code(8);
        idle(UNLOCK + 20);

        // Invalid simultaneous a+b followed by b,c,d.
        press(4'b0011, 5, 2);
        press(4'b0010, 5, 2);
        press(4'b0100, 5, 2);
        press(4'b1000, 5, 2);
        idle(20);
        check_eq("multi_fcnt", int'(fail_cnt), 1);

        // Key held through reset produces no press.
        keys = 4'b0100;
        do_reset("held");
        repeat (3) step();
        keys = 4'd0;
        repeat (4) step();
        check_eq("held_digit", int'(digit_cnt), 0);
        check_eq("held_state", int'(state_dbg), 0);

        // Reset mid-entry and mid-unlock.
        press(4'b0001, 5, 2);
        press(4'b0010, 5, 2);
        step();
        check_eq("mid_entry_digit", int'(digit_cnt), m_cnt);
        do_reset("rst_entry");
        enter_code(5);
        repeat (6) step();
        check_eq("mid_unlock_unlock", int'(unlock), 1);
        do_reset("rst_unlock");

        // Randomized entries.
        for (int e = 0; e < 25; e++) begin
            bit good;
            good = ($urandom_range(0, 9) < 4);
            for (int i = 0; i < CODE_LEN; i++) begin
                a = $urandom_range(0, 3);
                if (good) a = pw_sym(i);
                mask = 4'(1 << a);
                if (!good && $urandom_range(0, 9) == 0) begin
                    b = (a + $urandom_range(1, 3)) % 4;
                    mask = mask | 4'(1 << b);
                end
                gap = $urandom_range(2, 60);
                if ($urandom_range(0, 39) == 0) gap = TIMEOUT + $urandom_range(50, 200);
                press(mask, gap, $urandom_range(1, 4));
            end
        end

        idle(TIMEOUT + 200);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) step();
        check_eq("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
